// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the digit-serial adder.
package serial_adder_pkg;

    localparam int WIDTH_DEF = 64;
    localparam int DIGIT_DEF = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Digit counter width; never narrower than one bit so a single-digit build still elaborates.
    function automatic int cnt_width(input int width, input int digit);
        int n_digits;
        n_digits = width / digit;
        return (n_digits > 1) ? $clog2(n_digits) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_64bit_digit_adder.sv
// DIGIT-bit ripple-carry full-adder slice used once per clock by the serial adder.
module digit_adder
    import serial_adder_pkg::*;
#(
    parameter int DIGIT = DIGIT_DEF
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);

    logic c;

    always_comb begin
        // NOTE: every output gets a default first, so no path through the block can infer a latch.
        s = '0;
        c = ci;
        // NOTE: blocking assignments here model the ripple: each bit sees the carry just computed.
        for (int i = 0; i < DIGIT; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/serial_adder_64bit.sv
// Digit-serial adder with start/done handshake: sum = a + b + cin, DIGIT bits per clock.
// Optional macro SERIAL_ADDER_64BIT_OVF_EN adds a signed-overflow output 'ovf'.
module serial_adder_64bit
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DIGIT = DIGIT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic             cout,
    output logic [WIDTH-1:0] sum
`ifdef SERIAL_ADDER_64BIT_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N_DIGITS = WIDTH / DIGIT;
    localparam int CW       = cnt_width(WIDTH, DIGIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(N_DIGITS - 1);

    if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
        $error("serial_adder_64bit: DIGIT must divide WIDTH exactly");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cout_q, cout_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] sum_shift;
    logic [DIGIT-1:0] dig_s;
    logic             dig_co;

    digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .a  (a_sh_q[DIGIT-1:0]),
        .b  (b_sh_q[DIGIT-1:0]),
        .ci (carry_q),
        .s  (dig_s),
        .co (dig_co)
    );

    // Each new digit enters the result from the MSB end, so after the last digit bit 0 is in place.
    if (DIGIT == WIDTH) begin : g_sum_whole
        assign sum_shift = dig_s;
    end else begin : g_sum_shift
        assign sum_shift = {dig_s, sum_q[WIDTH-1:DIGIT]};
    end

`ifdef SERIAL_ADDER_64BIT_OVF_EN
    logic ovf_q, ovf_d;
    logic c_into_msb;

    // Carry into a bit is recoverable from its sum and operand bits.
    assign c_into_msb = a_sh_q[DIGIT-1] ^ b_sh_q[DIGIT-1] ^ dig_s[DIGIT-1];
`endif

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cout_d  = cout_q;
        sum_d   = sum_q;
`ifdef SERIAL_ADDER_64BIT_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> DIGIT;
                b_sh_d  = b_sh_q >> DIGIT;
                carry_d = dig_co;
                sum_d   = sum_shift;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cout_d  = dig_co;
`ifdef SERIAL_ADDER_64BIT_OVF_EN
                    ovf_d   = c_into_msb ^ dig_co;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the operand shift registers are reset as well, so no X ever reaches the adder slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
            sum_q   <= sum_d;
        end
    end

`ifdef SERIAL_ADDER_64BIT_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign busy = busy_q;
    assign done = done_q;
    assign cout = cout_q;
    assign sum  = sum_q;

endmodule

// File: tb/tb_serial_adder_64bit.sv
// Scoreboard bench for serial_adder_64bit: vectors, wrap-around, busy/back-to-back, mid-run reset.
module tb_serial_adder_64bit;

    localparam int W   = 64;
    localparam int LAT = 64;
    localparam int TMO = 200;
    localparam int NV  = 12;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cin   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic         cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADDER_64BIT_OVF_EN
    logic         ovf;
`endif

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    serial_adder_64bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .cout  (cout),
        .sum   (sum)
`ifdef SERIAL_ADDER_64BIT_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    // Reference: full-width add with an explicit carry bit; signed overflow from operand/result signs.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] full;
        exp_t       m;
        full   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        m.sum  = full[W-1:0];
        m.cout = full[W];
        m.ovf  = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        return m;
    endfunction

    task automatic test_reset();
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++;
        if (cout !== 1'b0) begin n_errors++; $display("FAIL reset_cout: got %b expected 0", cout); end
        n_checks++;
        if (sum !== '0) begin n_errors++; $display("FAIL reset_sum: got %h expected 0", sum); end
`ifdef SERIAL_ADDER_64BIT_OVF_EN
        n_checks++;
        if (ovf !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
    endtask

    task automatic test_vectors();
        logic [W-1:0] va [NV];
        logic [W-1:0] vb [NV];
        logic         vc [NV];
        exp_t         e;
        int           lat;
        va[0] = 64'd2;    vb[0] = 64'd5;     vc[0] = 1'b0;
        va[1] = 64'd1234; vb[1] = 64'd1123;  vc[1] = 1'b0;
        va[2] = 64'd20;   vb[2] = 64'd2012;  vc[2] = 1'b1;
        va[3] = 64'd75;   vb[3] = 64'd75123; vc[3] = 1'b1;
        va[4] = 64'd128;  vb[4] = 64'd12890; vc[4] = 1'b0;
        va[5] = 64'd200;  vb[5] = 64'd20123; vc[5] = 1'b0;
        va[6] = 64'hFFFF_FFFF_FFFF_FFFF; vb[6] = 64'd0; vc[6] = 1'b1;
        va[7] = 64'h7FFF_FFFF_FFFF_FFFF; vb[7] = 64'd1; vc[7] = 1'b0;
        va[8] = 64'h8000_0000_0000_0000; vb[8] = 64'h8000_0000_0000_0000; vc[8] = 1'b0;
        for (int i = 9; i < NV; i++) begin
            va[i] = {$urandom, $urandom};
            vb[i] = {$urandom, $urandom};
            vc[i] = 1'($urandom_range(1));
        end
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            a = va[i]; b = vb[i]; cin = vc[i]; start = 1'b1;
            sb.push_back(model(va[i], vb[i], vc[i]));
            @(posedge clk); #1;
            start = 1'b0;
            a = ~a; b = {$urandom, $urandom}; cin = ~cin;
            n_checks++;
            if (busy !== 1'b1) begin n_errors++; $display("FAIL vec%0d_busy_after_accept: got %b expected 1", i, busy); end
            lat = 0;
            while (done !== 1'b1 && lat < TMO) begin
                @(posedge clk); #1;
                lat++;
            end
            n_checks++;
            if (lat != LAT) begin n_errors++; $display("FAIL vec%0d_latency: got %0d expected %0d", i, lat, LAT); end
            if (sb.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL vec%0d_scoreboard: got empty queue expected one entry", i);
            end else begin
                e = sb.pop_front();
                n_checks++;
                if (sum !== e.sum) begin n_errors++; $display("FAIL vec%0d_sum: got %h expected %h", i, sum, e.sum); end
                n_checks++;
                if (cout !== e.cout) begin n_errors++; $display("FAIL vec%0d_cout: got %b expected %b", i, cout, e.cout); end
                n_checks++;
                if (busy !== 1'b0) begin n_errors++; $display("FAIL vec%0d_busy_at_done: got %b expected 0", i, busy); end
`ifdef SERIAL_ADDER_64BIT_OVF_EN
                n_checks++;
                if (ovf !== e.ovf) begin n_errors++; $display("FAIL vec%0d_ovf: got %b expected %b", i, ovf, e.ovf); end
`endif
                @(posedge clk); #1;
                n_checks++;
                if (done !== 1'b0) begin n_errors++; $display("FAIL vec%0d_done_pulse: got %b expected 0", i, done); end
                n_checks++;
                if (sum !== e.sum) begin n_errors++; $display("FAIL vec%0d_sum_hold: got %h expected %h", i, sum, e.sum); end
            end
        end
    endtask

    // start held high for the whole first run: the mid-run operands must be ignored, and the
    // still-high start in the done cycle launches the second sum.
    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        @(negedge clk);
        a = 64'd1000; b = 64'd2345; cin = 1'b1; start = 1'b1;
        sb.push_back(model(64'd1000, 64'd2345, 1'b1));
        @(posedge clk); #1;
        a = 64'hDEAD_BEEF_0000_0001; b = 64'h0123_4567_89AB_CDEF; cin = 1'b0;
        sb.push_back(model(64'hDEAD_BEEF_0000_0001, 64'h0123_4567_89AB_CDEF, 1'b0));
        lat = 0;
        while (done !== 1'b1 && lat < TMO) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat != LAT) begin n_errors++; $display("FAIL b2b_first_latency: got %0d expected %0d", lat, LAT); end
        e = sb.pop_front();
        n_checks++;
        if (sum !== e.sum) begin n_errors++; $display("FAIL b2b_first_sum: got %h expected %h", sum, e.sum); end
        n_checks++;
        if (cout !== e.cout) begin n_errors++; $display("FAIL b2b_first_cout: got %b expected %b", cout, e.cout); end
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL b2b_second_accept: got busy %b expected 1", busy); end
        lat = 0;
        while (done !== 1'b1 && lat < TMO) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat != LAT) begin n_errors++; $display("FAIL b2b_second_latency: got %0d expected %0d", lat, LAT); end
        e = sb.pop_front();
        n_checks++;
        if (sum !== e.sum) begin n_errors++; $display("FAIL b2b_second_sum: got %h expected %h", sum, e.sum); end
        n_checks++;
        if (cout !== e.cout) begin n_errors++; $display("FAIL b2b_second_cout: got %b expected %b", cout, e.cout); end
    endtask

    task automatic test_reset_abort();
        exp_t e;
        int   lat;
        int   seen_done;
        @(negedge clk);
        a = 64'hFFFF_0000_FFFF_0000; b = 64'h1111_1111_1111_1111; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_errors++; $display("FAIL abort_done: got %b expected 0", done); end
        n_checks++;
        if (cout !== 1'b0) begin n_errors++; $display("FAIL abort_cout: got %b expected 0", cout); end
        n_checks++;
        if (sum !== '0) begin n_errors++; $display("FAIL abort_sum: got %h expected 0", sum); end
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < LAT + 16; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen_done++;
        end
        n_checks++;
        if (seen_done != 0) begin n_errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", seen_done); end
        @(negedge clk);
        a = 64'd200; b = 64'd20123; cin = 1'b0; start = 1'b1;
        sb.push_back(model(64'd200, 64'd20123, 1'b0));
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < TMO) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat != LAT) begin n_errors++; $display("FAIL abort_restart_latency: got %0d expected %0d", lat, LAT); end
        e = sb.pop_front();
        n_checks++;
        if (sum !== e.sum) begin n_errors++; $display("FAIL abort_restart_sum: got %h expected %h", sum, e.sum); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_vectors();
        test_back_to_back();
        test_reset_abort();
        n_checks++;
        if (sb.size() != 0) begin n_errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
